// File: rtl/addsub_pkg.sv
// Shared definitions for the sequenced add/sub accumulator: opcodes, FSM states,
// flag layout and saturation limits.
package addsub_pkg;

    localparam int ACC_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/addsub_accum_seq_if.sv
// Request, adder-slice and result signals of the accumulator sequencer.
// The sequencer uses the slave modport; its environment uses master.
interface addsub_accum_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ctrl;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_flags;
    logic             ovf_sticky;

    modport slave (
        input  in_valid, in_op, in_data, add_sum, add_cout, add_ovf, out_ready,
        output in_ready, add_a, add_b, add_ctrl, out_valid, out_data, out_flags, ovf_sticky
    );

    modport master (
        output in_valid, in_op, in_data, add_sum, add_cout, add_ovf, out_ready,
        input  in_ready, add_a, add_b, add_ctrl, out_valid, out_data, out_flags, ovf_sticky
    );
endinterface

// File: rtl/addsub_flag_gen.sv
// Turns the external slice outputs into the post-op accumulator value and
// {Z,N,C,V}; LOAD and CLR bypass the slice.
module addsub_flag_gen
    import addsub_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH,
    parameter bit SAT_EN = 1'b0
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             ovf,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

    logic c_s;
    logic v_s;

    // Result select, saturation clamp and flag packing
    always_comb begin
        result = ZERO;
        c_s    = 1'b0;
        v_s    = 1'b0;
        case (op)
            OP_LOAD: result = operand;
            OP_ADD, OP_SUB: begin
                c_s = cout;
                v_s = ovf;
                // The clamp direction follows the sign of the accumulator before the op.
                if (SAT_EN && ovf) begin
                    result = acc[WIDTH-1] ? SAT_LO : SAT_HI;
                end else begin
                    result = sum;
                end
            end
            OP_CLR:  result = ZERO;
            default: result = acc;
        endcase
        flags = pack_flags(result == ZERO, result[WIDTH-1], c_s, v_s);
    end

endmodule

// File: rtl/addsub_accum_seq.sv
// Sequencer around the external 16-bit add/sub slice: accept an op, drive the
// slice for one EXEC cycle, capture the result and hold it until consumed.
module addsub_accum_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH  = ACC_WIDTH,
    parameter bit SAT_EN = 1'b0
) (
    input logic                clk,
    input logic                rst,
    addsub_accum_seq_if.slave  bus
);
    state_e           state_r;
    state_e           state_nxt_s;
    op_e              op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] operand_r;
    logic             add_ctrl_r;
    logic [3:0]       out_flags_r;
    logic             ovf_sticky_r;
    logic [WIDTH-1:0] result_s;
    logic [3:0]       flags_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = HOLD;
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            EXEC:    in_ready_s  = 1'b0;
            HOLD:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    assign accept_s = in_ready_s & bus.in_valid;

    // Request capture; add_ctrl is registered so it is stable across EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= OP_LOAD;
            operand_r  <= {WIDTH{1'b0}};
            add_ctrl_r <= 1'b0;
        end else if (accept_s) begin
            op_r       <= op_e'(bus.in_op);
            operand_r  <= bus.in_data;
            add_ctrl_r <= (bus.in_op == OP_SUB);
        end
    end

    addsub_flag_gen #(
        .WIDTH  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_flag_gen (
        .op      (op_r),
        .acc     (acc_r),
        .operand (operand_r),
        .sum     (bus.add_sum),
        .cout    (bus.add_cout),
        .ovf     (bus.add_ovf),
        .result  (result_s),
        .flags   (flags_s)
    );

    // Result capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= {WIDTH{1'b0}};
            out_flags_r  <= 4'b0000;
            ovf_sticky_r <= 1'b0;
        end else if (state_r == EXEC) begin
            acc_r       <= result_s;
            out_flags_r <= flags_s;
            if (op_r == OP_CLR) begin
                ovf_sticky_r <= 1'b0;
            end else begin
                ovf_sticky_r <= ovf_sticky_r | flags_s[FLAG_V];
            end
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.add_a      = acc_r;
    assign bus.add_b      = operand_r;
    assign bus.add_ctrl   = add_ctrl_r;
    assign bus.out_data   = acc_r;
    assign bus.out_flags  = out_flags_r;
    assign bus.ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_addsub_accum_seq.sv
// Bench for addsub_accum_seq: wrap (SAT_EN=0) and saturating (SAT_EN=1) copies
// run the same op table against a behavioural add/sub slice.
module tb_addsub_accum_seq;
    import addsub_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        sticky;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        int          hold;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic clk;
    logic rst;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic        out_ready;

    addsub_accum_seq_if #(.WIDTH(16)) if0 ();
    addsub_accum_seq_if #(.WIDTH(16)) if1 ();

    addsub_accum_seq #(.WIDTH(16), .SAT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    addsub_accum_seq #(.WIDTH(16), .SAT_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    // Behavioural add/sub slice: returns {O, C_out, SUM}
    function automatic logic [17:0] slice(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [15:0] bb;
        logic [16:0] t;
        bb = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
        return {(a[15] == bb[15]) && (t[15] != a[15]), t[16], t[15:0]};
    endfunction

    assign {if0.add_ovf, if0.add_cout, if0.add_sum} = slice(if0.add_a, if0.add_b, if0.add_ctrl);
    assign {if1.add_ovf, if1.add_cout, if1.add_sum} = slice(if1.add_a, if1.add_b, if1.add_ctrl);
    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
    assign if0.in_op = in_op;        assign if1.in_op = in_op;
    assign if0.in_data = in_data;    assign if1.in_data = in_data;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   failures;
    int   cyc;
    bit   hs_seen;
    exp_t cur0, cur1;
    exp_t q0[$];
    exp_t q1[$];
    int   hs_edges[$];
    logic [15:0] prev0, prev1;
    vec_t vecs[$];

    function automatic exp_t mke(input logic [15:0] d, input logic [3:0] f, input logic s);
        exp_t e;
        e.data = d; e.flags = f; e.sticky = s;
        return e;
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] data, input int hold,
                                input exp_t e0, input exp_t e1);
        vec_t v;
        v.op = op; v.data = data; v.hold = hold; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_beat(input int d, input logic [15:0] od, input logic [3:0] of, input logic os);
        exp_t e;
        if (d == 0) begin
            chk("d0_beat_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("d0_out_data", 32'(od), 32'(e.data));
                chk("d0_out_flags", 32'(of), 32'(e.flags));
                chk("d0_ovf_sticky", 32'(os), 32'(e.sticky));
            end
        end else begin
            chk("d1_beat_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("d1_out_data", 32'(od), 32'(e.data));
                chk("d1_out_flags", 32'(of), 32'(e.flags));
                chk("d1_ovf_sticky", 32'(os), 32'(e.sticky));
            end
        end
    endtask

    // One clock: observe handshakes/beats at negedge, then step past the rising edge
    task automatic cycle();
        @(negedge clk);
        hs_seen = 1'b0;
        if (if0.in_valid && if0.in_ready) begin
            q0.push_back(cur0);
            hs_seen = 1'b1;
            hs_edges.push_back(cyc);
        end
        if (if1.in_valid && if1.in_ready) q1.push_back(cur1);
        if (if0.out_valid && if0.out_ready) check_beat(0, if0.out_data, if0.out_flags, if0.ovf_sticky);
        if (if1.out_valid && if1.out_ready) check_beat(1, if1.out_data, if1.out_flags, if1.ovf_sticky);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        cur0 = v.e0; cur1 = v.e1;
        in_valid = 1'b1; in_op = v.op; in_data = v.data;
        out_ready = (v.hold == 0);
        n = 0;
        do begin cycle(); n++; end while (!hs_seen && n < 8);
        chk("handshake_seen", 32'(hs_seen), 32'd1);
        in_valid = 1'b0;
        // EXEC cycle: slice operands and control
        chk("d0_exec_add_a", 32'(if0.add_a), 32'(prev0));
        chk("d1_exec_add_a", 32'(if1.add_a), 32'(prev1));
        chk("exec_add_b", 32'(if0.add_b), 32'(v.data));
        chk("exec_add_ctrl", 32'(if0.add_ctrl), 32'(v.op == OP_SUB));
        chk("exec_out_valid", 32'(if0.out_valid), 32'd0);
        chk("exec_in_ready", 32'(if1.in_ready), 32'd0);
        cycle();
        chk("d0_hold_out_valid", 32'(if0.out_valid), 32'd1);
        chk("d1_hold_out_valid", 32'(if1.out_valid), 32'd1);
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'b1; in_op = OP_CLR; in_data = 16'hDEAD;
            cycle();
            chk("bp_out_valid", 32'(if0.out_valid), 32'd1);
            chk("bp_in_ready", 32'(if0.in_ready), 32'd0);
            if (q0.size() != 0) chk("bp_d0_out_data", 32'(if0.out_data), 32'(q0[0].data));
            if (q1.size() != 0) chk("bp_d1_out_data", 32'(if1.out_data), 32'(q1[0].data));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        do begin cycle(); n++; end while ((q0.size() != 0 || q1.size() != 0) && n < 4);
        chk("beat_drained", 32'(q0.size() + q1.size()), 32'd0);
        chk("post_out_valid", 32'(if0.out_valid), 32'd0);
        chk("post_in_ready", 32'(if0.in_ready), 32'd1);
        prev0 = v.e0.data;
        prev1 = v.e1.data;
    endtask

    initial begin
        int k;
        int n;
        checks = 0; failures = 0; cyc = 0; hs_seen = 1'b0;
        prev0 = 16'h0000; prev1 = 16'h0000;
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 16'h0000; out_ready = 1'b1;
        cur0 = mke(16'h0000, 4'b0000, 1'b0); cur1 = cur0;

        // Op table: {op, operand, backpressure cycles, expected wrap DUT, expected saturating DUT}
        vecs.push_back(mk(OP_LOAD, 16'h7FFF, 0, mke(16'h7FFF, 4'b0000, 1'b0), mke(16'h7FFF, 4'b0000, 1'b0)));
        vecs.push_back(mk(OP_ADD,  16'h0001, 0, mke(16'h8000, 4'b0101, 1'b1), mke(SAT_MAX,   4'b0001, 1'b1)));
        vecs.push_back(mk(OP_CLR,  16'h0000, 0, mke(16'h0000, 4'b1000, 1'b0), mke(16'h0000, 4'b1000, 1'b0)));
        vecs.push_back(mk(OP_LOAD, 16'h0005, 0, mke(16'h0005, 4'b0000, 1'b0), mke(16'h0005, 4'b0000, 1'b0)));
        vecs.push_back(mk(OP_SUB,  16'h0007, 0, mke(16'hFFFE, 4'b0100, 1'b0), mke(16'hFFFE, 4'b0100, 1'b0)));
        vecs.push_back(mk(OP_LOAD, 16'h1234, 0, mke(16'h1234, 4'b0000, 1'b0), mke(16'h1234, 4'b0000, 1'b0)));
        vecs.push_back(mk(OP_SUB,  16'h1234, 0, mke(16'h0000, 4'b1010, 1'b0), mke(16'h0000, 4'b1010, 1'b0)));
        vecs.push_back(mk(OP_LOAD, 16'hFFFF, 0, mke(16'hFFFF, 4'b0100, 1'b0), mke(16'hFFFF, 4'b0100, 1'b0)));
        vecs.push_back(mk(OP_ADD,  16'h0001, 0, mke(16'h0000, 4'b1010, 1'b0), mke(16'h0000, 4'b1010, 1'b0)));
        vecs.push_back(mk(OP_LOAD, 16'h8000, 0, mke(16'h8000, 4'b0100, 1'b0), mke(16'h8000, 4'b0100, 1'b0)));
        vecs.push_back(mk(OP_SUB,  16'h0001, 0, mke(16'h7FFF, 4'b0011, 1'b1), mke(SAT_MIN,   4'b0111, 1'b1)));
        vecs.push_back(mk(OP_ADD,  16'h0000, 5, mke(16'h7FFF, 4'b0000, 1'b1), mke(16'h8000, 4'b0100, 1'b1)));
        vecs.push_back(mk(OP_CLR,  16'h0000, 0, mke(16'h0000, 4'b1000, 1'b0), mke(16'h0000, 4'b1000, 1'b0)));

        repeat (2) cycle();
        rst = 1'b0;
        chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_data", 32'(if0.out_data), 32'd0);
        chk("rst_out_flags", 32'(if0.out_flags), 32'd0);
        chk("rst_ovf_sticky", 32'(if0.ovf_sticky), 32'd0);
        chk("rst_add_ctrl", 32'(if0.add_ctrl), 32'd0);
        chk("rst_add_b", 32'(if1.add_b), 32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back requests: one op accepted every third cycle, ADD 1 x4 from 0
        hs_edges.delete();
        in_valid = 1'b1; in_op = OP_ADD; in_data = 16'h0001; out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && (k < 4 || q0.size() != 0 || q1.size() != 0); i++) begin
            cur0 = mke(16'(k + 1), 4'b0000, 1'b0);
            cur1 = cur0;
            cycle();
            if (hs_seen) begin
                k++;
                if (k == 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("tp_accepted", 32'(k), 32'd4);
        chk("tp_drained", 32'(q0.size() + q1.size()), 32'd0);
        for (int i = 0; i + 1 < hs_edges.size(); i++) chk("tp_spacing", 32'(hs_edges[i+1] - hs_edges[i]), 32'd3);
        prev0 = 16'h0004; prev1 = 16'h0004;

        // Leave ovf_sticky set, then reset while an op sits in EXEC
        run_op(mk(OP_ADD, 16'h7FFF, 0, mke(16'h8003, 4'b0101, 1'b1), mke(SAT_MAX, 4'b0001, 1'b1)));
        in_valid = 1'b1; in_op = OP_LOAD; in_data = 16'h1234;
        n = 0;
        do begin cycle(); n++; end while (!hs_seen && n < 8);
        chk("rst_mid_handshake", 32'(hs_seen), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        q0.delete(); q1.delete();
        chk("midrst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(if1.out_valid), 32'd0);
        chk("midrst_d0_acc", 32'(if0.out_data), 32'd0);
        chk("midrst_d1_acc", 32'(if1.out_data), 32'd0);
        chk("midrst_d0_sticky", 32'(if0.ovf_sticky), 32'd0);
        repeat (3) cycle();
        chk("midrst_no_beat", 32'(if0.out_valid | if1.out_valid), 32'd0);
        prev0 = 16'h0000; prev1 = 16'h0000;
        run_op(mk(OP_ADD, 16'h0000, 0, mke(16'h0000, 4'b1000, 1'b0), mke(16'h0000, 4'b1000, 1'b0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
